// File: rtl/strip_alloc_scheduler.sv
`timescale 1ns/1ps
// Purpose : first-fit placement of programs into 13 fixed-height strips (IDs 1..13).
// Latency : response valid k edges after accept, k = candidate strips examined (1..3).
// Backpres: response held in RESP until resp_ready_i; req_ready_o low outside IDLE or while flushing.
//
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   req_valid_i/req_ready_o        request handshake, req_height_i / req_width_i payload
//   flush_i                        clears all strip fills (honoured only in IDLE)
//   resp_valid_o/resp_ready_i      response handshake
//   resp_ok_o, resp_strip_id_o,    placement result (id/x are 0 on reject)
//   resp_x_o
//   busy_o                         high whenever a request is in flight
// Optional: define STRIP_ALLOC_STATS_EN to add place_count_o / reject_count_o.
module strip_alloc_scheduler #(
   parameter int STRIP_WIDTH = 128,
   parameter int PW_BITS     = 5,
   parameter int XW          = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [4:0]         req_height_i,
   input  logic [PW_BITS-1:0] req_width_i,
   input  logic               flush_i,
   output logic               resp_valid_o,
   input  logic               resp_ready_i,
   output logic               resp_ok_o,
   output logic [3:0]         resp_strip_id_o,
   output logic [XW-1:0]      resp_x_o,
   output logic               busy_o
`ifdef STRIP_ALLOC_STATS_EN
   ,
   output logic [15:0]        place_count_o,
   output logic [15:0]        reject_count_o
`endif
);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   localparam logic [XW:0] SW = (XW+1)'(STRIP_WIDTH);

   state_t               state_q, state_d;
   logic [4:0]           hgt_q;
   logic [PW_BITS-1:0]   wid_q;
   logic [1:0]           idx_q;
   logic [XW-1:0]        fill_q [1:13];
   logic                 ok_q;
   logic [3:0]           id_q;
   logic [XW-1:0]        x_q;

   logic [1:0]           n_cand;
   logic [3:0]           cand_id;
   logic [XW-1:0]        fill_sel;
   logic [XW:0]          sum;
   logic                 fits;
   logic                 advance;
   logic                 accept;
   logic                 resp_hs;

   assign req_ready_o     = (state_q == IDLE) && !flush_i;
   assign accept          = req_valid_i && req_ready_o;
   assign resp_valid_o    = (state_q == RESP);
   assign resp_hs         = resp_valid_o && resp_ready_i;
   assign busy_o          = (state_q != IDLE);
   assign resp_ok_o       = ok_q;
   assign resp_strip_id_o = id_q;
   assign resp_x_o        = x_q;

   // Height -> candidate list; idx_q walks the list for the ambiguous heights.
   always_comb begin
      n_cand  = 2'd0;
      cand_id = 4'd0;
      case (hgt_q)
         5'd4:  begin n_cand = 2'd1; cand_id = 4'd10; end
         5'd5:  begin n_cand = 2'd1; cand_id = 4'd8;  end
         5'd6:  begin n_cand = 2'd1; cand_id = 4'd6;  end
         5'd7:  begin n_cand = 2'd1; cand_id = 4'd4;  end
         5'd9:  begin n_cand = 2'd1; cand_id = 4'd3;  end
         5'd10: begin n_cand = 2'd1; cand_id = 4'd5;  end
         5'd11: begin n_cand = 2'd1; cand_id = 4'd7;  end
         5'd12: begin n_cand = 2'd1; cand_id = 4'd9;  end
         5'd8:  begin n_cand = 2'd2; cand_id = (idx_q == 2'd0) ? 4'd1 : 4'd2; end
         5'd13, 5'd14, 5'd15, 5'd16:
                begin n_cand = 2'd3; cand_id = 4'd11 + {2'b00, idx_q}; end
         default: ;
      endcase
   end

   // Mux-style read so an empty candidate list never indexes outside 1..13.
   always_comb begin
      fill_sel = '0;
      for (int i = 1; i <= 13; i++) begin
         if (cand_id == 4'(i)) fill_sel = fill_q[i];
      end
   end

   // One extra bit so the sum cannot wrap before the capacity compare.
   assign sum     = {1'b0, fill_sel} + (XW+1)'(wid_q);
   assign fits    = (wid_q != '0) && (n_cand != 2'd0) && (sum <= SW);
   assign advance = (wid_q != '0) && !fits && ((idx_q + 2'd1) < n_cand);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SCAN;
         SCAN:    if (!advance) state_d = RESP;
         RESP:    if (resp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hgt_q <= '0;
         wid_q <= '0;
         idx_q <= '0;
         ok_q  <= 1'b0;
         id_q  <= '0;
         x_q   <= '0;
      end else begin
         if (accept) begin
            hgt_q <= req_height_i;
            wid_q <= req_width_i;
            idx_q <= '0;
         end
         if (state_q == SCAN) begin
            if (fits) begin
               ok_q <= 1'b1;
               id_q <= cand_id;
               x_q  <= fill_sel;
            end else if (advance) begin
               idx_q <= idx_q + 2'd1;
            end else begin
               ok_q <= 1'b0;
               id_q <= '0;
               x_q  <= '0;
            end
         end
      end
   end

   // Fill is committed during SCAN so the very next request sees it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 1; i <= 13; i++) fill_q[i] <= '0;
      end else if ((state_q == IDLE) && flush_i) begin
         for (int i = 1; i <= 13; i++) fill_q[i] <= '0;
      end else if ((state_q == SCAN) && fits) begin
         for (int i = 1; i <= 13; i++) begin
            if (cand_id == 4'(i)) fill_q[i] <= sum[XW-1:0];
         end
      end
   end

`ifdef STRIP_ALLOC_STATS_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         place_count_o  <= '0;
         reject_count_o <= '0;
      end else if ((state_q == IDLE) && flush_i) begin
         place_count_o  <= '0;
         reject_count_o <= '0;
      end else if (resp_hs) begin
         if (ok_q && (place_count_o != 16'hFFFF))
            place_count_o <= place_count_o + 16'd1;
         if (!ok_q && (reject_count_o != 16'hFFFF))
            reject_count_o <= reject_count_o + 16'd1;
      end
   end
`else
   logic unused_hs;
   assign unused_hs = resp_hs;
`endif

endmodule

// File: tb/tb_strip_alloc_scheduler.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for strip_alloc_scheduler against a list-based placement model.
// Latency : measures edges from accept to resp_valid_o and compares to candidates examined.
// Backpres: exercises held responses with resp_ready_i low for several cycles.
module tb_strip_alloc_scheduler;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       req_valid_i;
   logic       req_ready_o;
   logic [4:0] req_height_i;
   logic [4:0] req_width_i;
   logic       flush_i;
   logic       resp_valid_o;
   logic       resp_ready_i;
   logic       resp_ok_o;
   logic [3:0] resp_strip_id_o;
   logic [7:0] resp_x_o;
   logic       busy_o;
`ifdef STRIP_ALLOC_STATS_EN
   logic [15:0] place_count_o;
   logic [15:0] reject_count_o;
`endif

   strip_alloc_scheduler #(.STRIP_WIDTH(128), .PW_BITS(5), .XW(8)) dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_height_i    (req_height_i),
      .req_width_i     (req_width_i),
      .flush_i         (flush_i),
      .resp_valid_o    (resp_valid_o),
      .resp_ready_i    (resp_ready_i),
      .resp_ok_o       (resp_ok_o),
      .resp_strip_id_o (resp_strip_id_o),
      .resp_x_o        (resp_x_o),
      .busy_o          (busy_o)
`ifdef STRIP_ALLOC_STATS_EN
      ,
      .place_count_o   (place_count_o),
      .reject_count_o  (reject_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: fill of each strip in columns, plus handshake tallies.
   int fill_m [14];
   int place_m;
   int reject_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 14; i++) fill_m[i] = 0;
      place_m  = 0;
      reject_m = 0;
   endtask

   // First-fit over the candidate list the height selects.
   task automatic model(input int h, input int w,
                        output bit ok, output int id, output int x, output int k);
      int c[$];
      case (h)
         4:  c = {10};
         5:  c = {8};
         6:  c = {6};
         7:  c = {4};
         9:  c = {3};
         10: c = {5};
         11: c = {7};
         12: c = {9};
         8:  c = {1, 2};
         13, 14, 15, 16: c = {11, 12, 13};
         default: ;
      endcase
      ok = 1'b0; id = 0; x = 0; k = 1;
      if (w != 0 && c.size() > 0) begin
         k = c.size();
         for (int i = 0; i < c.size(); i++) begin
            if (fill_m[c[i]] + w <= 128) begin
               ok = 1'b1;
               id = c[i];
               x  = fill_m[c[i]];
               fill_m[c[i]] += w;
               k  = i + 1;
               break;
            end
         end
      end
   endtask

   task automatic send(input int h, input int w, input int hold, input string tag);
      bit eok;
      int eid, ex, ek, k;
      model(h, w, eok, eid, ex, ek);
      @(negedge clk_i);
      check({tag, ".req_ready"}, 32'(req_ready_o), 1);
      req_valid_i  = 1'b1;
      req_height_i = 5'(h);
      req_width_i  = 5'(w);
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      check({tag, ".busy_after_accept"}, 32'(busy_o), 1);
      k = 0;
      while (resp_valid_o !== 1'b1 && k < 8) begin
         @(posedge clk_i);
         #1;
         k++;
      end
      check({tag, ".latency"}, k, ek);
      check({tag, ".ok"}, 32'(resp_ok_o), 32'(eok));
      check({tag, ".id"}, 32'(resp_strip_id_o), eid);
      check({tag, ".x"}, 32'(resp_x_o), ex);
      for (int j = 0; j < hold; j++) begin
         @(posedge clk_i);
         #1;
         check({tag, ".hold_valid"}, 32'(resp_valid_o), 1);
         check({tag, ".hold_ok"}, 32'(resp_ok_o), 32'(eok));
         check({tag, ".hold_id"}, 32'(resp_strip_id_o), eid);
         check({tag, ".hold_x"}, 32'(resp_x_o), ex);
         check({tag, ".hold_req_ready"}, 32'(req_ready_o), 0);
         check({tag, ".hold_busy"}, 32'(busy_o), 1);
      end
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      resp_ready_i = 1'b0;
      if (eok) place_m++;
      else     reject_m++;
      check({tag, ".valid_after_hs"}, 32'(resp_valid_o), 0);
      check({tag, ".busy_after_hs"}, 32'(busy_o), 0);
`ifdef STRIP_ALLOC_STATS_EN
      check({tag, ".place_count"}, 32'(place_count_o), place_m);
      check({tag, ".reject_count"}, 32'(reject_count_o), reject_m);
`endif
   endtask

   task automatic do_flush(input string tag);
      @(negedge clk_i);
      flush_i      = 1'b1;
      req_valid_i  = 1'b1;
      req_height_i = 5'd10;
      req_width_i  = 5'd3;
      #1;
      check({tag, ".req_ready_during_flush"}, 32'(req_ready_o), 0);
      @(posedge clk_i);
      #1;
      check({tag, ".no_accept_during_flush"}, 32'(busy_o), 0);
      @(negedge clk_i);
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      model_clear();
   endtask

   initial begin
      rst_n_i      = 1'b0;
      req_valid_i  = 1'b0;
      req_height_i = '0;
      req_width_i  = '0;
      flush_i      = 1'b0;
      resp_ready_i = 1'b0;
      model_clear();

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst.valid", 32'(resp_valid_o), 0);
      check("rst.ok", 32'(resp_ok_o), 0);
      check("rst.id", 32'(resp_strip_id_o), 0);
      check("rst.x", 32'(resp_x_o), 0);
      check("rst.busy", 32'(busy_o), 0);
      check("rst.req_ready", 32'(req_ready_o), 1);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("post_rst.req_ready", 32'(req_ready_o), 1);
      check("post_rst.busy", 32'(busy_o), 0);

      // Unique heights
      send(10, 20, 0, "h10_first");
      send(10, 20, 0, "h10_second");
      send(4, 16, 0, "h4");

      // Ambiguous height 8: strip 1 to 120, spill to strip 2, exact fit on strip 1
      for (int i = 0; i < 7; i++) send(8, 16, 0, "h8_fill");
      send(8, 8, 0, "h8_fill120");
      send(8, 16, 0, "h8_spill_strip2");
      send(8, 8, 0, "h8_exact_fit");

      // Heights 13..16: fill strips 11 and 12, then 13, then reject on full
      for (int i = 0; i < 16; i++) send(13, 16, 0, "h13_fill");
      send(15, 4, 0, "h15_strip13");
      for (int i = 0; i < 4; i++) send(16, 31, 0, "h16_fill13");
      send(14, 1, 0, "h14_all_full");

      // Invalid heights and zero width
      send(3, 5, 0, "rej_h3");
      send(17, 5, 0, "rej_h17");
      send(20, 5, 0, "rej_h20");
      send(10, 0, 0, "rej_w0");
      send(8, 0, 0, "rej_w0_ambig");
      send(10, 1, 0, "h10_after_rejects");

      // Backpressure
      send(9, 7, 5, "backpressure");

      // Reset while scanning
      @(negedge clk_i);
      req_valid_i  = 1'b1;
      req_height_i = 5'd13;
      req_width_i  = 5'd5;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b0;
      #1;
      check("midscan_rst.valid", 32'(resp_valid_o), 0);
      check("midscan_rst.busy", 32'(busy_o), 0);
      check("midscan_rst.ok", 32'(resp_ok_o), 0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      model_clear();
      send(10, 5, 0, "after_rst_h10");

      // Flush in IDLE
      send(12, 9, 0, "pre_flush_h12");
      send(12, 9, 0, "pre_flush_h12b");
      do_flush("flush");
      send(12, 3, 0, "post_flush_h12");

      // Randomized traffic with occasional flushes
      for (int n = 0; n < 150; n++) begin
         int h, w;
         h = $urandom_range(0, 20);
         w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
         if ($urandom_range(0, 24) == 0) do_flush("rand_flush");
         send(h, w, $urandom_range(0, 3), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
